// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder
// Brief    : M-stage data-port responder: byte-lane stores with no stall, and
//            loads with a programmable latency that stall until data is valid.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_responder #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memreqM,
  input  logic        memwriteM,
  input  logic [31:0] aluoutM,
  input  logic [31:0] writedataM,
  input  logic [3:0]  byteenM,
  output logic [31:0] readdataM,
  output logic        memstallM,
  output logic        addr_errM,
  output logic [7:0]  err_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam bit         c_zeroWait = (WAIT_CYCLES == 0);
  localparam logic [3:0] c_waitInit = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t              r_state;
  state_t              w_nextState;
  logic [3:0]          r_waitCnt;
  logic [ADDR_W-1:0]   r_index;
  logic [7:0]          r_errCnt;
  logic [31:0]         r_mem [2**ADDR_W];

  logic [ADDR_W-1:0]   w_index;
  logic [ADDR_W-1:0]   w_readIdx;
  logic                w_aligned;
  logic                w_stall;
  logic                w_addrErr;
  logic                w_store;
  logic                w_loadAccept;
  logic                w_startWait;
  logic                w_capture;
  logic                w_unused;

  // Upper address bits alias onto the same words.
  assign w_index   = aluoutM[ADDR_W+1:2];
  assign w_aligned = (aluoutM[1:0] == 2'b00);
  assign w_unused  = ^aluoutM[31:ADDR_W+2];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState  = r_state;
    w_stall      = 1'b0;
    w_addrErr    = 1'b0;
    w_store      = 1'b0;
    w_loadAccept = 1'b0;
    w_startWait  = 1'b0;
    w_capture    = 1'b0;
    w_readIdx    = r_index;
    case (r_state)
      IDLE: begin
        if (memreqM) begin
          if (!w_aligned) begin
            w_addrErr = 1'b1;
          end else if (memwriteM) begin
            w_store = 1'b1;
          end else begin
            w_stall      = 1'b1;
            w_loadAccept = 1'b1;
            if (c_zeroWait) begin
              w_capture   = 1'b1;
              w_readIdx   = w_index;
              w_nextState = RESP;
            end else begin
              w_startWait = 1'b1;
              w_nextState = WAIT;
            end
          end
        end
      end
      WAIT: begin
        w_stall = 1'b1;
        if (r_waitCnt == 4'd0) begin
          w_capture   = 1'b1;
          w_nextState = RESP;
        end
      end
      RESP: begin
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  assign memstallM = rst & w_stall;
  assign addr_errM = rst & w_addrErr;
  assign err_count = r_errCnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_waitCnt <= 4'd0;
      r_index   <= '0;
      readdataM <= 32'd0;
      r_errCnt  <= 8'd0;
    end else begin
      if (w_loadAccept) begin
        r_index <= w_index;
      end
      if (w_startWait) begin
        r_waitCnt <= c_waitInit;
      end else if (r_state == WAIT && r_waitCnt != 4'd0) begin
        r_waitCnt <= r_waitCnt - 4'd1;
      end
      if (w_capture) begin
        readdataM <= r_mem[w_readIdx];
      end
      if (w_addrErr && r_errCnt != 8'hFF) begin
        r_errCnt <= r_errCnt + 8'd1;
      end
    end
  end

  // RAM has no reset; contents survive rst.
  always_ff @(posedge clk) begin
    if (rst && w_store) begin
      for (int b = 0; b < 4; b++) begin
        if (byteenM[b]) begin
          r_mem[w_index][8*b +: 8] <= writedataM[8*b +: 8];
        end
      end
    end
  end

endmodule
`default_nettype wire
